// File: rtl/spi_target_pkg.sv
// Shared constants and types for the SPI target.
package spi_target_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = $clog2(BYTE_W);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_target_rx_fifo.sv
// Receive FIFO: a push while full is dropped unless a pop happens in the same cycle.
module spi_target_rx_fifo
  import spi_target_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic              Mclk,
  input  logic              nReset,
  input  logic              push_i,
  input  logic [BYTE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [BYTE_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic              overflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              overflow_q, overflow_d;
  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic              do_push, do_pop;

  assign empty_o    = (wr_ptr_q == rd_ptr_q);
  assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign head_o     = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overflow_o = overflow_q;

  // When full, a simultaneous pop frees the slot the push is about to write.
  always_comb begin
    do_pop     = pop_i & ~empty_o;
    do_push    = push_i & (~full_o | do_pop);
    overflow_d = push_i & full_o & ~do_pop;
    wr_ptr_d   = do_push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = do_pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
  end

  // Pointer and overflow-pulse registers.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage array; contents are only observed through a valid read pointer.
  always_ff @(posedge Mclk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end
  end

endmodule

// File: rtl/spi_target.sv
// SPI target, mode 0, LSB-first, 8-bit frames, oversampled from Mclk.
//
// state  | meaning
// IDLE   | spi_cs high; bus clock ignored, miso held at 0
// ACTIVE | spi_cs low; shifting bytes in on clk rise, out on clk fall
module spi_target
  import spi_target_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic              Mclk,
  input  logic              nReset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  input  logic [BYTE_W-1:0] Tx_data,
  input  logic              Tx_load,
  output logic              Tx_ready,
  output logic              Tx_underrun,
  output logic [BYTE_W-1:0] Rx_data,
  output logic              Rx_valid,
  input  logic              Rx_read,
  output logic              Rx_overflow,
  output logic              Frame_active
);

  logic [SYNC_STAGES-1:0] clk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   clk_dly_q, cs_dly_q;
  logic                   clk_s, cs_s, mosi_s;
  logic                   clk_rise, clk_fall, cs_rise, cs_fall;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic              reload_q, reload_d;
  logic [BYTE_W-1:0] hold_q, hold_d;
  logic              hold_full_q, hold_full_d;
  logic              underrun_q, underrun_d;
  logic              push_q, push_d;
  logic [BYTE_W-1:0] push_byte_q, push_byte_d;
  logic              miso_q, miso_d;
  logic              consume;
  logic              fifo_full, fifo_empty;

  assign clk_s  = clk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign clk_rise =  clk_s & ~clk_dly_q;
  assign clk_fall = ~clk_s &  clk_dly_q;
  assign cs_rise  =  cs_s  & ~cs_dly_q;
  assign cs_fall  = ~cs_s  &  cs_dly_q;

  assign spi_miso     = miso_q;
  assign Tx_ready     = ~hold_full_q;
  assign Tx_underrun  = underrun_q;
  assign Rx_valid     = ~fifo_empty;
  assign Frame_active = ~cs_s;

  // Bus synchronisers plus one delayed copy for edge detection; cs idles high.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      clk_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b1;
    end else begin
      clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], spi_clk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      clk_dly_q   <= clk_s;
      cs_dly_q    <= cs_s;
    end
  end

  // Frame FSM, shift registers and transmit holding register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    reload_d    = reload_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = 1'b0;
    push_d      = 1'b0;
    push_byte_d = push_byte_q;
    consume     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d  = ACTIVE;
          consume  = 1'b1;
          cnt_d    = '0;
          reload_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          // A partial byte is simply abandoned; it was never pushed.
          state_d  = IDLE;
          cnt_d    = '0;
          reload_d = 1'b0;
        end else begin
          if (clk_rise) begin
            rx_shift_d[cnt_q] = mosi_s;
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
              push_d      = 1'b1;
              push_byte_d = rx_shift_d;
              cnt_d       = '0;
              reload_d    = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          if (clk_fall) begin
            if (reload_q) begin
              consume  = 1'b1;
              reload_d = 1'b0;
            end else begin
              tx_shift_d = tx_shift_q >> 1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A consume wins over a same-cycle load, so the load is dropped.
    if (consume) begin
      tx_shift_d  = hold_full_q ? hold_q : '0;
      underrun_d  = ~hold_full_q;
      hold_full_d = 1'b0;
    end else if (Tx_load && !hold_full_q) begin
      hold_d      = Tx_data;
      hold_full_d = 1'b1;
    end

    miso_d = (state_q == ACTIVE) ? tx_shift_q[0] : 1'b0;
  end

  // Register update for the FSM and datapath.
  always_ff @(posedge Mclk or negedge nReset) begin
    if (!nReset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      reload_q    <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      push_q      <= 1'b0;
      push_byte_q <= '0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      reload_q    <= reload_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      push_q      <= push_d;
      push_byte_q <= push_byte_d;
      miso_q      <= miso_d;
    end
  end

  spi_target_rx_fifo #(
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .Mclk        (Mclk),
    .nReset      (nReset),
    .push_i      (push_q),
    .push_data_i (push_byte_q),
    .pop_i       (Rx_read),
    .head_o      (Rx_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .overflow_o  (Rx_overflow)
  );

  logic unused_full;
  assign unused_full = fifo_full;

endmodule
